// File: rtl/mem_cycle_ctrl.sv
// Memory cycle controller: arbitrates the single memory port between the
// instruction-fetch and load/store requesters, classifies each access as
// N (non-sequential) or S (sequential), and inserts wait states per access.
// Requesters advance on the ack strobe instead of a stretched memory clock.
module mem_cycle_ctrl #(
  parameter int unsigned N_WAIT = 2,
  parameter int unsigned S_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  // load/store requester
  input  logic        dt_req,
  input  logic [31:0] dt_addr,
  input  logic        dt_we,
  input  logic [31:0] dt_wdata,
  output logic        dt_gnt,
  output logic        dt_ack,
  output logic [31:0] dt_rdata,
  // memory side
  output logic [31:0] mem_address,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic [1:0]  cycle_type
);

  localparam int unsigned CNT_MAX = (N_WAIT > S_WAIT) ? N_WAIT : S_WAIT;
  localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic        PORT_IF = 1'b0;
  localparam logic        PORT_DT = 1'b1;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t         state_q, state_d;
  logic           cur_port_q, cur_port_d;
  logic           cur_we_q, cur_we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           seq_q, seq_d;
  logic           last_port_q, last_port_d;
  logic [31:0]    last_addr_q, last_addr_d;
  logic           last_valid_q, last_valid_d;

  logic           complete;
  logic           free;
  logic           grant;
  logic           gnt_port;
  logic [31:0]    gnt_addr;
  logic           gnt_seq;

  // Completion, arbitration and grants; data port has fixed priority.
  always_comb begin
    complete = (state_q == ST_ACCESS) && (cnt_q == '0) && mem_ready;
    free     = (state_q == ST_IDLE) || complete;
    dt_gnt   = free && dt_req && !rst;
    if_gnt   = free && if_req && !dt_req && !rst;
    grant    = dt_gnt || if_gnt;
    gnt_port = dt_gnt ? PORT_DT : PORT_IF;
    gnt_addr = dt_gnt ? dt_addr : if_addr;
  end

  // Next-state logic. The "last access" record is updated in the completion
  // cycle, and the sequential test uses those updated values so that a grant
  // in the same cycle compares against the access that is just finishing.
  always_comb begin
    state_d      = state_q;
    cur_port_d   = cur_port_q;
    cur_we_d     = cur_we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    seq_d        = seq_q;
    last_port_d  = last_port_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;

    if (complete) begin
      last_valid_d = 1'b1;
      last_port_d  = cur_port_q;
      last_addr_d  = addr_q;
    end

    // An IDLE grant can never be sequential: only completion cycles qualify.
    gnt_seq = complete && last_valid_d && (gnt_port == last_port_d) &&
              (gnt_addr == last_addr_d + 32'd4);

    if ((state_q == ST_ACCESS) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end

    if (grant) begin
      state_d    = ST_ACCESS;
      cur_port_d = gnt_port;
      cur_we_d   = dt_gnt ? dt_we : 1'b0;
      addr_d     = gnt_addr;
      wdata_d    = dt_gnt ? dt_wdata : wdata_q;
      seq_d      = gnt_seq;
      cnt_d      = gnt_seq ? CW'(S_WAIT) : CW'(N_WAIT);
    end else if (complete) begin
      state_d      = ST_IDLE;
      last_valid_d = 1'b0;
    end
  end

  // State and access registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_port_q   <= PORT_IF;
      cur_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      seq_q        <= 1'b0;
      last_port_q  <= PORT_IF;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_port_q   <= cur_port_d;
      cur_we_q     <= cur_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      seq_q        <= seq_d;
      last_port_q  <= last_port_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
    end
  end

  // Outputs decode from registered state, so reset drops them at once.
  always_comb begin
    mem_address    = addr_q;
    mem_write_data = wdata_q;
    mem_read_en    = (state_q == ST_ACCESS) && !cur_we_q;
    mem_write_en   = (state_q == ST_ACCESS) && cur_we_q;
    if_ack         = complete && (cur_port_q == PORT_IF);
    dt_ack         = complete && (cur_port_q == PORT_DT);
    if_rdata       = mem_read_data;
    dt_rdata       = mem_read_data;
    cycle_type     = (state_q == ST_ACCESS) ? {1'b0, seq_q} : 2'b10;
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Testbench for mem_cycle_ctrl: directed scenarios plus a randomized run,
// all checked every cycle against a transaction-timing reference model.
module tb_mem_cycle_ctrl;

  localparam int N_WAIT = 2;
  localparam int S_WAIT = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        dt_req, dt_we, dt_gnt, dt_ack;
  logic [31:0] dt_addr, dt_wdata, dt_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read_en, mem_write_en, mem_ready;
  logic [1:0]  cycle_type;

  mem_cycle_ctrl #(.N_WAIT(N_WAIT), .S_WAIT(S_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ack(if_ack), .if_rdata(if_rdata),
    .dt_req(dt_req), .dt_addr(dt_addr), .dt_we(dt_we), .dt_wdata(dt_wdata),
    .dt_gnt(dt_gnt), .dt_ack(dt_ack), .dt_rdata(dt_rdata),
    .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .cycle_type(cycle_type)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } dop_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  int cyc      = 0;
  int lc       = 0;

  // memory behind the DUT pins, and the reference model's own copy
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  // requester queues: head is held on the bus until granted
  logic [31:0] if_q[$];
  dop_t        dt_q[$];

  // reference model: the access in flight and when it may first complete
  logic        m_busy = 1'b0, m_port = 1'b0, m_we = 1'b0, m_seq = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int          m_earliest = 0;
  logic        g_if, g_dt;

  // per-test observation logs, bit/index = cycle within the test
  logic [15:0] ifgnt_v, dtgnt_v, ifack_v, dtack_v, ren_v, wen_v;
  logic [1:0]  ct_a [16];
  logic [31:0] if_rd_a [16];
  logic [31:0] dt_rd_a [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: inputs are already set; check outputs against the
  // model, advance the model, then let the edge happen.
  task automatic run_cycle();
    logic        comp, free_c, seq;
    logic [1:0]  exp_ct;
    logic [31:0] req_addr;
    mem_read_data = mem_read_en ? mem_rd(mem_address) : 32'h0;
    #1;
    if (lc < 16) begin
      ifgnt_v[lc] = if_gnt; dtgnt_v[lc] = dt_gnt;
      ifack_v[lc] = if_ack; dtack_v[lc] = dt_ack;
      ren_v[lc] = mem_read_en; wen_v[lc] = mem_write_en;
      ct_a[lc] = cycle_type; if_rd_a[lc] = if_rdata; dt_rd_a[lc] = dt_rdata;
    end
    g_if = 1'b0;
    g_dt = 1'b0;
    if (rst) begin
      check("rst_if_gnt", if_gnt, 0);
      check("rst_dt_gnt", dt_gnt, 0);
      check("rst_if_ack", if_ack, 0);
      check("rst_dt_ack", dt_ack, 0);
      check("rst_read_en", mem_read_en, 0);
      check("rst_write_en", mem_write_en, 0);
      check("rst_cycle_type", cycle_type, 2'b10);
      m_busy = 1'b0;
    end else begin
      comp   = m_busy && (cyc >= m_earliest) && mem_ready;
      free_c = !m_busy || comp;
      exp_ct = m_busy ? {1'b0, m_seq} : 2'b10;
      check("cycle_type", cycle_type, exp_ct);
      check("mem_read_en", mem_read_en, m_busy && !m_we);
      check("mem_write_en", mem_write_en, m_busy && m_we);
      if (m_busy) check("mem_address", mem_address, m_addr);
      if (m_busy && m_we) check("mem_write_data", mem_write_data, m_wdata);
      check("if_ack", if_ack, comp && !m_port);
      check("dt_ack", dt_ack, comp && m_port);
      if (comp) begin
        n_txn++;
        if (m_we) begin
          shadow[m_addr] = m_wdata;
          $display("txn %0d cyc %0d: data write addr=%h data=%h seq=%0d", n_txn, cyc, m_addr, m_wdata, m_seq);
        end else begin
          check(m_port ? "dt_rdata" : "if_rdata", m_port ? dt_rdata : if_rdata, sh_rd(m_addr));
          $display("txn %0d cyc %0d: %s read addr=%h data=%h seq=%0d", n_txn, cyc,
                   m_port ? "data" : "fetch", m_addr, m_port ? dt_rdata : if_rdata, m_seq);
        end
      end
      g_dt = free_c && dt_req;
      g_if = free_c && if_req && !dt_req;
      check("dt_gnt", dt_gnt, g_dt);
      check("if_gnt", if_gnt, g_if);
      if (g_dt || g_if) begin
        req_addr   = g_dt ? dt_addr : if_addr;
        seq        = comp && (m_port == g_dt) && (req_addr == m_addr + 32'd4);
        m_busy     = 1'b1;
        m_port     = g_dt;
        m_we       = g_dt && dt_we;
        m_addr     = req_addr;
        m_wdata    = g_dt ? dt_wdata : m_wdata;
        m_seq      = seq;
        m_earliest = cyc + 1 + (seq ? S_WAIT : N_WAIT);
      end else if (comp) begin
        m_busy = 1'b0;
      end
    end
    if (mem_write_en && mem_ready && dt_ack) mem[mem_address] = mem_write_data;
    lc++;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    if_req  = (if_q.size() != 0);
    if_addr = if_req ? if_q[0] : 32'h0;
    dt_req  = (dt_q.size() != 0);
    if (dt_req) begin
      dt_addr = dt_q[0].addr; dt_we = dt_q[0].we; dt_wdata = dt_q[0].wdata;
    end else begin
      dt_addr = 32'h0; dt_we = 1'b0; dt_wdata = 32'h0;
    end
    run_cycle();
    if (g_if) void'(if_q.pop_front());
    if (g_dt) void'(dt_q.pop_front());
  endtask

  task automatic start_test();
    lc = 0;
    ifgnt_v = '0; dtgnt_v = '0; ifack_v = '0; dtack_v = '0; ren_v = '0; wen_v = '0;
  endtask

  initial begin
    logic [31:0] if_next;
    dop_t        d;
    rst = 1'b1; mem_ready = 1'b1;
    if_req = 1'b0; if_addr = '0; dt_req = 1'b0; dt_addr = '0; dt_we = 1'b0; dt_wdata = '0;
    mem_read_data = '0;
    @(negedge clk);

    // reset state
    start_test();
    repeat (2) step();
    check("reset_mem_address", mem_address, 32'h0);
    check("reset_mem_write_data", mem_write_data, 32'h0);
    rst = 1'b0;
    repeat (2) step();

    // single fetch N access
    start_test();
    if_q.push_back(32'h100);
    repeat (6) step();
    check("t1_if_gnt", ifgnt_v[5:0], 6'b000001);
    check("t1_if_ack", ifack_v[5:0], 6'b001000);
    check("t1_ct1", ct_a[1], 2'b00);
    check("t1_ct3", ct_a[3], 2'b00);
    check("t1_ct4", ct_a[4], 2'b10);
    check("t1_rdata", if_rd_a[3], 32'h5A5A_1334);

    // fetch stream: N then two S
    repeat (2) step();
    start_test();
    if_q.push_back(32'h100); if_q.push_back(32'h104); if_q.push_back(32'h108);
    repeat (7) step();
    check("t2_if_gnt", ifgnt_v[6:0], 7'b0011001);
    check("t2_if_ack", ifack_v[6:0], 7'b0111000);
    check("t2_ct3", ct_a[3], 2'b00);
    check("t2_ct4", ct_a[4], 2'b01);
    check("t2_ct5", ct_a[5], 2'b01);
    check("t2_ct6", ct_a[6], 2'b10);

    // simultaneous requests: data wins, fetch follows as N
    repeat (2) step();
    start_test();
    if_q.push_back(32'h204);
    d = '{addr: 32'h200, we: 1'b0, wdata: 32'h0};
    dt_q.push_back(d);
    repeat (8) step();
    check("t3_dt_gnt", dtgnt_v[7:0], 8'b00000001);
    check("t3_dt_ack", dtack_v[7:0], 8'b00001000);
    check("t3_if_gnt", ifgnt_v[7:0], 8'b00001000);
    check("t3_if_ack", ifack_v[7:0], 8'b01000000);
    check("t3_ct4", ct_a[4], 2'b00);
    check("t3_dt_rdata", dt_rd_a[3], 32'h5A5A_1034);

    // write stretched by mem_ready low for two cycles at the end
    repeat (2) step();
    start_test();
    d = '{addr: 32'h300, we: 1'b1, wdata: 32'hDEAD_BEEF};
    dt_q.push_back(d);
    for (int i = 0; i < 7; i++) begin
      mem_ready = !(i == 3 || i == 4);
      step();
    end
    mem_ready = 1'b1;
    check("t4_write_en", wen_v[6:0], 7'b0111110);
    check("t4_dt_ack", dtack_v[6:0], 7'b0100000);
    check("t4_mem", mem_rd(32'h300), 32'hDEAD_BEEF);

    // address wrap is still sequential
    repeat (2) step();
    start_test();
    if_q.push_back(32'hFFFF_FFFC); if_q.push_back(32'h0000_0000);
    repeat (6) step();
    check("t5_if_ack", ifack_v[5:0], 6'b011000);
    check("t5_ct4", ct_a[4], 2'b01);

    // reset mid-access abandons it; next fetch is N
    repeat (2) step();
    start_test();
    if_q.push_back(32'h100);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    check("t6_rden_before", ren_v[1], 1);
    check("t6_rden_rst", ren_v[2], 0);
    check("t6_ct_rst", ct_a[2], 2'b10);
    check("t6_no_ack", ifack_v[5:0], 6'b000000);
    start_test();
    if_q.push_back(32'h104);
    repeat (5) step();
    check("t6_if_ack", ifack_v[4:0], 5'b01000);
    check("t6_ct1", ct_a[1], 2'b00);

    // randomized traffic
    if_next = 32'h400;
    for (int i = 0; i < 1500; i++) begin
      if (if_q.size() == 0 && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 7))
          0:       if_next = 32'($urandom_range(0, 255)) << 2;
          1:       if_next = 32'hFFFF_FFF8;
          default: ;
        endcase
        if_q.push_back(if_next);
        if_next = if_next + 32'd4;
      end
      if (dt_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        d.addr  = 32'h200 + (32'($urandom_range(0, 15)) << 2);
        d.we    = 1'($urandom_range(0, 1));
        d.wdata = $urandom;
        dt_q.push_back(d);
        if ($urandom_range(0, 2) == 0) begin
          d.addr = d.addr + 32'd4;
          dt_q.push_back(d);
        end
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    if_q.delete();
    dt_q.delete();
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_cycle_ctrl.md
# mem_cycle_ctrl

Memory cycle controller and two-port arbiter for the CPU's single memory port. Shares the port between the instruction-fetch requester and the load/store data requester. Classifies each access as non-sequential (N), sequential (S) or idle (I), and inserts a parameterised number of wait states per access. The block drives the memory's address, read-enable and write-enable inputs and returns read data and a completion strobe to the winning requester; pipeline stages use that strobe as their advance condition in place of a stretched memory clock.

## Interface
- N_WAIT, 2: wait cycles added to an N access (N access = N_WAIT+1 cycles).
- S_WAIT, 0: wait cycles added to an S access.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_ack  out  1  fetch access completes this cycle; if_rdata valid.
- if_rdata  out  32  fetch read data (= mem_read_data).
- dt_req  in  1  data request; held with dt_addr/dt_we/dt_wdata until dt_gnt.
- dt_addr  in  32  data address.
- dt_we  in  1  1 = write, 0 = read.
- dt_wdata  in  32  write data.
- dt_gnt  out  1  data request accepted this cycle (combinational).
- dt_ack  out  1  data access completes this cycle; dt_rdata valid for reads.
- dt_rdata  out  32  data read data (= mem_read_data).
- mem_address  out  32  registered access address.
- mem_read_en  out  1  read enable, high through a whole read access.
- mem_write_en  out  1  write enable, high through a whole write access.
- mem_write_data  out  32  registered write data.
- mem_read_data  in  32  memory read data.
- mem_ready  in  1  memory can finish this cycle; low stretches the access.
- cycle_type  out  2  {nMREQ,SEQ}: N=00, S=01, I=10 (C=11 never driven).

## Operation
- States: IDLE, ACCESS. Registers:
  - cur_port (fetch/data) and cur_we
  - mem_address, mem_write_data
  - wait counter cnt, sized for max(N_WAIT,S_WAIT)
  - seq flag
  - last_port, last_addr, last_valid
- free = IDLE, or (ACCESS and cnt==0 and mem_ready) (completion cycle).
- Arbitration when free: dt_req wins; otherwise if_req. Exactly one gnt is asserted, and only when free. Fixed priority means sustained dt_req can starve fetch; this is intended.
- A grant latches the port, address, we and wdata, sets seq, loads cnt = seq ? S_WAIT : N_WAIT, and enters or stays in ACCESS.
- seq = 1 iff all of the following hold; otherwise the access is N:
  - last_valid
  - granted port == last_port
  - granted addr == last_addr + 4, computed modulo 2^32 (0xFFFFFFFC -> 0x00000000 is sequential)
  - the grant occurs in a completion cycle, with no IDLE gap.
- ACCESS:
  - cnt decrements each cycle while nonzero.
  - At cnt==0, completion waits for mem_ready; cnt holds at 0 while mem_ready is low.
  - Completion asserts the matching ack for exactly that cycle.
- On completion, last_port and last_addr are updated and last_valid is set. With no grant, the next state is IDLE and mem_read_en/mem_write_en drop. Entering IDLE clears last_valid.
- cycle_type: IDLE -> 10; ACCESS -> {0,seq}.

## Timing
- Reset values:
  - state IDLE, cnt 0, last_valid 0, last_port fetch, last_addr 0
  - mem_address 0, mem_write_data 0, mem_read_en 0, mem_write_en 0
  - ack outputs 0, cycle_type 10
  - gnt outputs forced 0 while rst is high.
- Reset mid-access abandons the access: no ack, enables drop asynchronously.
- Latency from grant edge to ack:
  - N access: N_WAIT+1 cycles.
  - S access: S_WAIT+1 cycles.
  - Plus one cycle per cycle that mem_ready is low at cnt==0.
- Back-to-back accesses: a grant in a completion cycle starts the next access on the following cycle with no bubble. Requesters may present the next request in the cycle after their gnt.
- Simultaneous ack and gnt to the same or the other port in one cycle are legal.
- A write is committed by memory in its completion cycle. A read's rdata is sampled by the requester on the edge ending the ack cycle.

## Test plan
- N_WAIT=2, S_WAIT=0. Single fetch at 0x100 -> if_gnt cycle 0; cycle_type 00 for cycles 1-3; if_ack cycle 3 with if_rdata = mem[0x100]; then cycle_type 10.
- Fetch stream 0x100, 0x104, 0x108 with if_req held -> first access N (3 cycles); next two S, 1 cycle each; if_ack on consecutive cycles; cycle_type 00,00,00,01,01.
- if_req and dt_req (read 0x200) both rise in cycle 0 -> dt_gnt only; dt_ack cycle 3; if_gnt in cycle 3; fetch is N (port change) with if_ack at cycle 6.
- Data write 0x300=0xDEADBEEF with mem_ready low for 2 cycles at cnt==0 -> mem_write_en high 5 cycles; dt_ack delayed 2 cycles; memory holds 0xDEADBEEF.
- Fetch 0xFFFFFFFC then 0x00000000 back-to-back -> second access is S (1 cycle).
- rst pulse in cycle 2 of an N read -> no ack; mem_read_en 0 and cycle_type 10 immediately. Next fetch to 0x104 after the prior 0x100 is N.
